// File: rtl/mem_bus_pkg.sv
// Shared definitions for responders on the picorv32 packed memory bus:
// field offsets of mem_packed_fwd/mem_packed_ret, bridge state encoding, timeout data.
package mem_bus_pkg;

    localparam int FWD_W     = 69;
    localparam int RET_W     = 33;
    localparam int WDATA_LSB = 37;
    localparam int WSTRB_LSB = 33;
    localparam int VALID_BIT = 32;
    localparam int READY_BIT = 32;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_WAIT,
        ST_MERGE,
        ST_RESP,
        ST_DONE
    } lb_state_e;

    // Byte lanes with a strobe take the new data, the others keep the old data.
    function automatic logic [31:0] byte_merge(input logic [31:0] new_data,
                                               input logic [31:0] old_data,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_packed_unpack.sv
// Combinational split of the packed forward bus into its fields; shared by all
// responders on the bus.
module mem_packed_unpack
    import mem_bus_pkg::*;
(
    input  logic [FWD_W-1:0] mem_packed_fwd,
    output logic [31:0]      addr,
    output logic             valid,
    output logic [3:0]       wstrb,
    output logic [31:0]      wdata
);

    assign addr  = mem_packed_fwd[31:0];
    assign valid = mem_packed_fwd[VALID_BIT];
    assign wstrb = mem_packed_fwd[WSTRB_LSB +: 4];
    assign wdata = mem_packed_fwd[WDATA_LSB +: 32];

endmodule

// File: rtl/mem_lb_bridge.sv
// picorv32 packed-bus responder that turns each access in its window into one
// local-bus cycle. Define MEM_LB_RMW_EN to turn partial writes into read-merge-write.
module mem_lb_bridge
    import mem_bus_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR     = 8'h07,
    parameter int          LB_ADW        = 22,
    parameter int          LB_READ_DELAY = 3,
    parameter int          TIMEOUT       = 64,
    parameter logic [31:0] TIMEOUT_DATA  = TIMEOUT_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FWD_W-1:0]  mem_packed_fwd,
    output logic [RET_W-1:0]  mem_packed_ret,
    output logic [LB_ADW-1:0] lb_addr,
    output logic              lb_write,
    output logic              lb_read,
    output logic [31:0]       lb_wdata,
    input  logic [31:0]       lb_rdata,
    input  logic              lb_rvalid,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [31:0] fwd_addr;
    logic        fwd_valid;
    logic [3:0]  fwd_wstrb;
    logic [31:0] fwd_wdata;

    mem_packed_unpack u_unpack (
        .mem_packed_fwd (mem_packed_fwd),
        .addr           (fwd_addr),
        .valid          (fwd_valid),
        .wstrb          (fwd_wstrb),
        .wdata          (fwd_wdata)
    );

    lb_state_e         state;
    lb_state_e         state_nxt;
    logic [LB_ADW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              hit;
    logic              wr_direct;
    logic              at_limit;
    logic              unused_ok;

    // Byte offset is meaningless on a word bus; LB_READ_DELAY is informational
    // because the bridge waits on lb_rvalid itself.
    assign unused_ok = ^{fwd_addr[1:0], (LB_READ_DELAY != 0)};

    assign hit      = fwd_valid && (fwd_addr[31:24] == BASE_ADDR);
    assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_LB_RMW_EN
    logic [3:0] wstrb_q;
    logic       rmw_q;
    assign wr_direct = (fwd_wstrb == 4'hF);
`else
    assign wr_direct = (fwd_wstrb != 4'h0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first, so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hit) state_nxt = wr_direct ? ST_WR : ST_RD;
            ST_WR:    state_nxt = ST_RESP;
            ST_RD:    state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (lb_rvalid) begin
`ifdef MEM_LB_RMW_EN
                    state_nxt = rmw_q ? ST_MERGE : ST_RESP;
`else
                    state_nxt = ST_RESP;
`endif
                end else if (at_limit) begin
                    state_nxt = ST_RESP;
                end
            end
`ifdef MEM_LB_RMW_EN
            ST_MERGE: state_nxt = ST_WR;
`endif
            ST_RESP:  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        lb_write       = (state == ST_WR);
        lb_read        = (state == ST_RD);
        mem_packed_ret = '0;
        if (state == ST_RESP) begin
            mem_packed_ret[READY_BIT] = 1'b1;
            mem_packed_ret[31:0]      = rdata_q;
        end
    end

    assign lb_addr  = addr_q;
    assign lb_wdata = wdata_q;

    // rdata_q is cleared at acceptance so writes answer with zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
`ifdef MEM_LB_RMW_EN
            wstrb_q     <= '0;
            rmw_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        addr_q  <= fwd_addr[LB_ADW+1:2];
                        wdata_q <= fwd_wdata;
                        rdata_q <= '0;
`ifdef MEM_LB_RMW_EN
                        wstrb_q <= fwd_wstrb;
                        rmw_q   <= !wr_direct && (fwd_wstrb != 4'h0);
`endif
                    end
                end
                ST_RD: cnt <= '0;
                ST_WAIT: begin
                    if (lb_rvalid) begin
                        rdata_q <= lb_rdata;
                    end else if (at_limit) begin
                        rdata_q     <= TIMEOUT_DATA;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef MEM_LB_RMW_EN
                ST_MERGE: begin
                    wdata_q <= byte_merge(wdata_q, rdata_q, wstrb_q);
                    rdata_q <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lb_bridge.sv
// Self-checking bench for mem_lb_bridge: directed cases plus randomized accesses
// checked against a word-level memory model of the local bus.
module tb_mem_lb_bridge;

    localparam int TIMEOUT = 64;
`ifdef MEM_LB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    typedef struct packed {
        bit          got;
        int          lat;
        int          n_rdy;
        int          n_wr;
        int          n_rd;
        int          n_junk;
        logic [31:0] rdata;
        logic [21:0] wr_addr;
        logic [31:0] wr_data;
        logic [21:0] rd_addr;
    } acc_obs_t;

    logic        clk;
    logic        rst;
    logic [68:0] fwd;
    logic [32:0] ret;
    logic [21:0] lb_addr;
    logic        lb_write;
    logic        lb_read;
    logic [31:0] lb_wdata;
    logic [31:0] lb_rdata;
    logic        lb_rvalid;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_lb_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .mem_packed_fwd (fwd),
        .mem_packed_ret (ret),
        .lb_addr        (lb_addr),
        .lb_write       (lb_write),
        .lb_read        (lb_read),
        .lb_wdata       (lb_wdata),
        .lb_rdata       (lb_rdata),
        .lb_rvalid      (lb_rvalid),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Local-bus responder: memory with a programmable read latency.
    logic [31:0] slv_mem [int];
    logic [31:0] ref_mem [int];
    int          rsp_delay = 3;
    bit          rsp_en = 1'b1;
    int          rd_cd = 0;
    logic [31:0] pend_data = '0;
    logic        mdl_rvalid = 1'b0;
    logic [31:0] mdl_rdata = '0;
    logic        force_rvalid = 1'b0;
    logic [31:0] force_rdata = '0;

    assign lb_rvalid = mdl_rvalid | force_rvalid;
    assign lb_rdata  = mdl_rvalid ? mdl_rdata : force_rdata;

    function automatic logic [31:0] dflt(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    always @(negedge clk) begin
        mdl_rvalid = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                mdl_rvalid = 1'b1;
                mdl_rdata  = pend_data;
            end
        end
        if (lb_write) slv_mem[int'(lb_addr)] = lb_wdata;
        if (lb_read && rsp_en) begin
            rd_cd     = rsp_delay;
            pend_data = slv_mem.exists(int'(lb_addr)) ? slv_mem[int'(lb_addr)] : dflt(int'(lb_addr));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Reference: what the CPU should see, derived from the bus rules at word level.
    task automatic model_access(input logic [31:0] addr, input logic [3:0] strb,
                                input logic [31:0] wdata, input int dly, output acc_obs_t e);
        int          a;
        logic [31:0] old;
        logic [31:0] mask;
        a   = int'(addr[23:2]);
        old = ref_rd(a);
        e   = '0;
        if (addr[31:24] == 8'h07) begin
            e.got   = 1'b1;
            e.n_rdy = 1;
            if (strb == 4'h0) begin
                e.n_rd = 1; e.rd_addr = 22'(a); e.rdata = old; e.lat = dly + 3;
            end else if (strb == 4'hF || !RMW) begin
                e.n_wr = 1; e.wr_addr = 22'(a); e.wr_data = wdata; e.lat = 3;
                ref_mem[a] = wdata;
            end else begin
                mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
                e.n_rd = 1; e.rd_addr = 22'(a);
                e.n_wr = 1; e.wr_addr = 22'(a);
                e.wr_data = (wdata & mask) | (old & ~mask);
                e.lat = dly + 5;
                ref_mem[a] = e.wr_data;
            end
        end
    endtask

    // Drives one CPU access from a negedge; valid is held two edges past the
    // ready sample, then the bus is watched a few more cycles.
    task automatic do_access(input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wdata, output acc_obs_t o);
        int cyc;
        int hold;
        o    = '0;
        hold = 0;
        fwd  = {wdata, strb, 1'b1, addr};
        cyc  = 0;
        while (cyc < TIMEOUT + 20) begin
            @(negedge clk);
            cyc++;
            if (lb_write) begin o.n_wr++; o.wr_addr = lb_addr; o.wr_data = lb_wdata; end
            if (lb_read) begin o.n_rd++; o.rd_addr = lb_addr; end
            if (ret[32]) begin
                o.n_rdy++;
                if (!o.got) begin o.got = 1'b1; o.lat = cyc + 1; o.rdata = ret[31:0]; hold = cyc; end
            end else if (ret != 33'h0) begin
                o.n_junk++;
            end
            if (o.got && cyc == hold + 2) fwd = '0;
            if (o.got && cyc == hold + 5) break;
        end
        fwd = '0;
    endtask

    task automatic check_access(input string tag, input acc_obs_t o, input acc_obs_t e);
        check({tag, ".ready"}, 64'(o.got), 64'(e.got));
        check({tag, ".n_ready"}, 64'(o.n_rdy), 64'(e.n_rdy));
        check({tag, ".n_write"}, 64'(o.n_wr), 64'(e.n_wr));
        check({tag, ".n_read"}, 64'(o.n_rd), 64'(e.n_rd));
        check({tag, ".ret_idle_zero"}, 64'(o.n_junk), 64'd0);
        if (e.got) begin
            check({tag, ".latency"}, 64'(o.lat), 64'(e.lat));
            check({tag, ".rdata"}, 64'(o.rdata), 64'(e.rdata));
        end
        if (e.n_wr > 0 && o.n_wr > 0) begin
            check({tag, ".wr_addr"}, 64'(o.wr_addr), 64'(e.wr_addr));
            check({tag, ".wr_data"}, 64'(o.wr_data), 64'(e.wr_data));
        end
        if (e.n_rd > 0 && o.n_rd > 0) check({tag, ".rd_addr"}, 64'(o.rd_addr), 64'(e.rd_addr));
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            force_rvalid = 1'b0;
            check({tag, ".ret"}, 64'(ret), 64'd0);
            check({tag, ".strobes"}, 64'({lb_write, lb_read}), 64'd0);
        end
    endtask

    initial begin
        acc_obs_t    o;
        acc_obs_t    e;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          pick;

        rst = 1'b1;
        fwd = '0;
        slv_mem[8]  = 32'hCAFEF00D; ref_mem[8]  = 32'hCAFEF00D;
        slv_mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
        repeat (3) @(negedge clk);
        check("reset.ret", 64'(ret), 64'd0);
        check("reset.lb_addr", 64'(lb_addr), 64'd0);
        check("reset.lb_wdata", 64'(lb_wdata), 64'd0);
        check("reset.strobes", 64'({lb_write, lb_read}), 64'd0);
        check("reset.timeout_err", 64'(timeout_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        rsp_delay = 3;
        model_access(32'h07000010, 4'hF, 32'h12345678, rsp_delay, e);
        do_access(32'h07000010, 4'hF, 32'h12345678, o);
        check_access("full_wr", o, e);
        check("full_wr.lb_addr_lit", 64'(o.wr_addr), 64'h4);

        model_access(32'h07000020, 4'h0, 32'h0, rsp_delay, e);
        do_access(32'h07000020, 4'h0, 32'h0, o);
        check_access("read", o, e);

        model_access(32'h07000040, 4'b0010, 32'h0000AB00, rsp_delay, e);
        do_access(32'h07000040, 4'b0010, 32'h0000AB00, o);
        check_access("partial", o, e);

        model_access(32'h07FFFFFC, 4'hF, 32'hA5C3_0F96, rsp_delay, e);
        do_access(32'h07FFFFFC, 4'hF, 32'hA5C3_0F96, o);
        check_access("top_wr", o, e);
        rsp_delay = 1;
        model_access(32'h07FFFFFF, 4'h0, 32'h0, rsp_delay, e);
        do_access(32'h07FFFFFF, 4'h0, 32'h0, o);
        check_access("top_rd", o, e);

        model_access(32'h06000000, 4'hF, 32'h55AA55AA, rsp_delay, e);
        do_access(32'h06000000, 4'hF, 32'h55AA55AA, o);
        check_access("miss", o, e);

        rsp_delay = TIMEOUT;
        model_access(32'h07000024, 4'h0, 32'h0, rsp_delay, e);
        do_access(32'h07000024, 4'h0, 32'h0, o);
        check_access("rvalid_at_limit", o, e);
        check("rvalid_at_limit.timeout_err", 64'(timeout_err), 64'd0);

        rsp_en = 1'b0;
        e = '0;
        e.got = 1'b1; e.n_rdy = 1; e.n_rd = 1; e.rd_addr = 22'd12;
        e.lat = TIMEOUT + 3; e.rdata = 32'hDEADBEEF;
        do_access(32'h07000030, 4'h0, 32'h0, o);
        check_access("timeout", o, e);
        check("timeout.err_set", 64'(timeout_err), 64'd1);
        force_rdata  = 32'h0BADF00D;
        force_rvalid = 1'b1;
        check_quiet("late_rvalid", 4);
        check("late_rvalid.err_sticky", 64'(timeout_err), 64'd1);
        rsp_en = 1'b1;

        for (int n = 0; n < 24; n++) begin
            pick = int'($urandom_range(0, 7));
            addr = {(pick == 0) ? 8'h08 : 8'h07, 24'($urandom)};
            if (pick >= 5) addr[23:2] = 22'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       strb = 4'hF;
                1:       strb = 4'h0;
                default: strb = 4'($urandom_range(1, 14));
            endcase
            wdata     = $urandom;
            rsp_delay = int'($urandom_range(1, 6));
            model_access(addr, strb, wdata, rsp_delay, e);
            do_access(addr, strb, wdata, o);
            check_access($sformatf("rnd%0d", n), o, e);
        end
        check("rnd.err_sticky", 64'(timeout_err), 64'd1);

        rsp_en = 1'b0;
        fwd = {32'h0, 4'h0, 1'b1, 32'h07000020};
        repeat (4) @(negedge clk);
        check("rst_wait.no_ready_yet", 64'(ret), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait.ret", 64'(ret), 64'd0);
        check("rst_wait.lb_addr", 64'(lb_addr), 64'd0);
        check("rst_wait.lb_wdata", 64'(lb_wdata), 64'd0);
        check("rst_wait.strobes", 64'({lb_write, lb_read}), 64'd0);
        check("rst_wait.timeout_err", 64'(timeout_err), 64'd0);
        fwd = '0;
        @(negedge clk);
        rst = 1'b0;
        force_rdata  = 32'h600DCAFE;
        force_rvalid = 1'b1;
        check_quiet("rst_wait.after", 4);
        rsp_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_lb_bridge.md
Name: mem_lb_bridge

Overview:
- Responder on the picorv32 packed memory bus (mem_packed_fwd/mem_packed_ret); initiator on the 32-bit local bus (lb_write/lb_read/lb_addr/lb_wdata, lb_rdata/lb_rvalid).
- Claims one BASE_ADDR window and turns each CPU access into a single local-bus cycle, or a read-modify-write for partial writes.
- A per-access timeout guarantees the CPU is always released.
- Return bus is zero when not responding, so it can be OR-merged with other responders.

Parameters:
- BASE_ADDR, 8'h07, match value for mem_addr[31:24].
- LB_ADW, 22, local-bus word-address width; lb_addr = mem_addr[LB_ADW+1:2].
- LB_READ_DELAY, 3, nominal lb_rvalid latency. Informational only; the bridge waits for lb_rvalid itself.
- TIMEOUT, 64, maximum cycles waited for lb_rvalid after lb_read.
- TIMEOUT_DATA, 32'hDEADBEEF, rdata returned on timeout.

Ports:
- clk  in  1  system clock, all logic.
- rst  in  1  synchronous active-high reset.
- mem_packed_fwd  in  69  [68:37] wdata, [36:33] wstrb, [32] valid, [31:0] addr.
- mem_packed_ret  out  33  [32] ready, [31:0] rdata.
- lb_addr  out  LB_ADW  local-bus word address.
- lb_write  out  1  one-cycle write strobe.
- lb_read  out  1  one-cycle read strobe.
- lb_wdata  out  32  write data.
- lb_rdata  in  32  read data, qualified by lb_rvalid.
- lb_rvalid  in  1  read-data valid.
- timeout_err  out  1  sticky; set on any timeout, cleared by rst.

Behaviour:
- Reset: state IDLE; all outputs 0 (mem_packed_ret, lb_addr, lb_write, lb_read, lb_wdata, timeout_err). Reset mid-transaction aborts with no ready; any later lb_rvalid is ignored.
- Hit: valid & addr[31:24]==BASE_ADDR, sampled in IDLE only.
- Address and wdata are registered at acceptance and held stable until DONE.
- IDLE, hit, wstrb==4'hF: go to WR.
- IDLE, hit, wstrb==0 (read): go to RD.
- IDLE, hit, wstrb partial: go to RD, with an rmw flag set (only when MEM_LB_RMW_EN is defined).
- WR: lb_write=1 for exactly 1 cycle, then RESP.
- RD: lb_read=1 for exactly 1 cycle, counter cleared, then WAIT.
- WAIT, lb_rvalid=1:
  - capture lb_rdata;
  - if rmw, go to MERGE;
  - otherwise go to RESP with rdata = captured data.
- WAIT, counter reaches TIMEOUT-1 with no lb_rvalid:
  - set timeout_err;
  - rdata = TIMEOUT_DATA;
  - go to RESP (an rmw access skips its write);
  - an lb_rvalid arriving in the same cycle as the timeout wins.
- MERGE: per byte i, merged[i] = wstrb[i] ? wdata[i] : captured[i]; then WR using merged data.
- RESP:
  - mem_packed_ret = {1'b1, rdata} for exactly 1 cycle;
  - rdata = 0 for writes;
  - then DONE.
- DONE: 1 idle cycle, because the CPU still holds valid in the cycle after ready; then IDLE.
- Latency, valid to ready: full write 3 cycles; read LB_READ_DELAY+3; RMW LB_READ_DELAY+5.
- Stray lb_rvalid outside WAIT is ignored.
- Non-hit accesses never produce a response.
- mem_packed_ret is 33'b0 in every state except RESP.

Optional Feature:
- Macro MEM_LB_RMW_EN.
- Defined: partial-strobe writes use the read-merge-write path described above.
- Undefined: partial-strobe writes go straight to WR with the full registered wdata (strobes ignored); the MERGE state and merge logic are not built.

Decomposition:
- Shared package mem_bus_pkg holds:
  - field offsets for fwd/ret (WDATA_LSB=37, WSTRB_LSB=33, VALID_BIT=32, READY_BIT=32);
  - the state encoding;
  - TIMEOUT_DATA default.
- One natural sub-module: mem_packed_unpack, a combinational split of fwd into addr/valid/wstrb/wdata. It is shared with other responders.

Test Plan:
- Full write: addr 0x07000010, wstrb F, wdata 0x12345678 -> lb_write 1 cycle with lb_addr 0x000004, lb_wdata 0x12345678; ret = 0x1_00000000 at cycle +3; ret 0 afterwards.
- Read: addr 0x07000020, lb_rvalid 3 cycles after lb_read with 0xCAFEF00D -> single ready pulse with rdata 0xCAFEF00D at cycle +6; valid held through DONE gives no second lb_read.
- RMW (MEM_LB_RMW_EN defined): wstrb 4'b0010, wdata 0x0000AB00, readback 0x11223344 -> lb_write with 0x1122AB44; without the macro -> lb_write 0x0000AB00 and no lb_read.
- Timeout: read with lb_rvalid never asserted -> ready with 0xDEADBEEF at TIMEOUT+3 cycles; timeout_err=1 and stays set; a late lb_rvalid is ignored.
- Miss/reset: addr 0x06000000 -> no lb strobes, ret stays 0. rst asserted during WAIT -> all outputs 0 the next cycle, no ready pulse.
